sdram_copy_engine: RTL

CSR-programmed Avalon-MM copy engine placed next to the PCIe-facing custom slave. The host writes source, destination and word count through the slave port, then writes the start word. The block moves the data SDRAM-to-SDRAM through its master port in batches of up to FIFO_DEPTH words, using an internal FIFO. Status and progress are readable by the host at any time.

---
 rtl/copy_engine_pkg.sv | 25 ++
 rtl/copy_fifo.sv | 47 ++++
 rtl/sdram_copy_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/copy_engine_pkg.sv
// rtl/copy_engine_pkg.sv - shared constants, CSR map and FSM state type for the SDRAM copy engine
package copy_engine_pkg;

  localparam int CSR_CTRL   = 0;
  localparam int CSR_SRC    = 1;
  localparam int CSR_DST    = 2;
  localparam int CSR_LEN    = 3;
  localparam int CSR_STATUS = 4;
  localparam int CSR_COUNT  = 5;

  localparam logic [31:0] START_WORD = 32'hF00B_F00B;
  localparam logic [31:0] ABORT_WORD = 32'hDEAD_F00B;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR
  } state_t;

endpackage

// File: rtl/copy_fifo.sv
// rtl/copy_fifo.sv - show-ahead synchronous FIFO holding one copy batch
module copy_fifo #(
  parameter int DATAWIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATAWIDTH-1:0]          push_data,
  input  logic                          pop,
  output logic [DATAWIDTH-1:0]          head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          count_q;
  logic                 do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/sdram_copy_engine.sv
// rtl/sdram_copy_engine.sv - CSR-programmed SDRAM-to-SDRAM copy engine with batched Avalon-MM master
module sdram_copy_engine
  import copy_engine_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int SLAVE_ADDRESSWIDTH  = 3,
  parameter int DATAWIDTH           = 32,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest
);
  localparam int MAW = MASTER_ADDRESSWIDTH;
  localparam int SAW = SLAVE_ADDRESSWIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [DATAWIDTH-1:0] remaining_q, remaining_d, count_q, count_d, rdata_q, rdata_d;
  logic [MAW-1:0]       rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [CW-1:0]        batch_q, batch_d, issued_q, issued_d, received_q, received_d;
  logic                 done_q, done_d, aborted_q, aborted_d, abort_req_q, abort_req_d;

  logic                 busy, csr_wr, csr_rd, ctrl_wr, start, abort_cmd;
  logic                 rd_accept, wr_accept, fifo_push, fifo_empty, fifo_full, unused_full;
  logic [CW-1:0]        fifo_count, received_inc;
  logic [DATAWIDTH-1:0] fifo_head, status;

  function automatic logic [CW-1:0] batch_of(input logic [DATAWIDTH-1:0] rem);
    return (rem >= DATAWIDTH'(FIFO_DEPTH)) ? DEPTH_C : rem[CW-1:0];
  endfunction

  assign busy         = (state_q != IDLE);
  assign csr_wr       = slave_chipselect && slave_write;
  assign csr_rd       = slave_chipselect && slave_read;
  assign ctrl_wr      = csr_wr && (slave_address == SAW'(CSR_CTRL));
  assign start        = ctrl_wr && (slave_writedata == DATAWIDTH'(START_WORD)) && !busy;
  assign abort_cmd    = ctrl_wr && (slave_writedata == DATAWIDTH'(ABORT_WORD)) && busy;
  assign rd_accept    = (state_q == RD_REQ) && !master_waitrequest;
  assign wr_accept    = (state_q == WR) && !master_waitrequest && !fifo_empty;
  // Read data is only meaningful inside a job; returns left over from a reset are dropped.
  assign fifo_push    = master_readdatavalid && busy;
  assign received_inc = received_q + {{(CW-1){1'b0}}, fifo_push};
  assign unused_full  = fifo_full;
  assign slave_readdata = rdata_q;

  copy_fifo #(
    .DATAWIDTH  (DATAWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (master_readdata),
    .pop       (wr_accept),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    case (state_q)
      RD_REQ: begin
        master_read    = 1'b1;
        master_address = rd_addr_q;
      end
      WR: begin
        master_write     = 1'b1;
        master_address   = wr_addr_q;
        master_writedata = fifo_head;
      end
      default: ;
    endcase
  end

  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = busy;
    status[STAT_DONE]    = done_q;
    status[STAT_ABORTED] = aborted_q;
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    batch_d     = batch_q;
    issued_d    = issued_q;
    received_d  = received_inc;
    done_d      = done_q;
    aborted_d   = aborted_q;
    abort_req_d = abort_req_q || abort_cmd;

    if (csr_rd) begin
      case (slave_address)
        SAW'(CSR_SRC):    rdata_d = src_q;
        SAW'(CSR_DST):    rdata_d = dst_q;
        SAW'(CSR_LEN):    rdata_d = len_q;
        SAW'(CSR_STATUS): rdata_d = status;
        SAW'(CSR_COUNT):  rdata_d = count_q;
        default:          rdata_d = '0;
      endcase
    end

    if (csr_wr && !busy) begin
      case (slave_address)
        SAW'(CSR_SRC): src_d = {slave_writedata[DATAWIDTH-1:2], 2'b00};
        SAW'(CSR_DST): dst_d = {slave_writedata[DATAWIDTH-1:2], 2'b00};
        SAW'(CSR_LEN): len_d = slave_writedata;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d      = (len_q == '0);
          aborted_d   = 1'b0;
          count_d     = '0;
          rd_addr_d   = src_q[MAW-1:0];
          wr_addr_d   = dst_q[MAW-1:0];
          remaining_d = len_q;
          batch_d     = batch_of(len_q);
          issued_d    = '0;
          received_d  = '0;
          if (len_q != '0) state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (rd_accept) begin
          rd_addr_d = rd_addr_q + MAW'(4);
          issued_d  = issued_q + CW'(1);
          if (issued_q + CW'(1) == batch_q)
            state_d = (received_inc == batch_q) ? WR : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (received_inc == batch_q) state_d = WR;
      end
      WR: begin
        if (wr_accept) begin
          wr_addr_d   = wr_addr_q + MAW'(4);
          count_d     = count_q + DATAWIDTH'(1);
          remaining_d = remaining_q - DATAWIDTH'(1);
          // Batch boundary: the only point where the job may end or be aborted.
          if (fifo_count == CW'(1)) begin
            if (remaining_q == DATAWIDTH'(1)) begin
              state_d     = IDLE;
              done_d      = 1'b1;
              abort_req_d = 1'b0;
            end else if (abort_req_q) begin
              state_d     = IDLE;
              aborted_d   = 1'b1;
              abort_req_d = 1'b0;
            end else begin
              state_d    = RD_REQ;
              batch_d    = batch_of(remaining_q - DATAWIDTH'(1));
              issued_d   = '0;
              received_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      batch_q     <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      abort_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      batch_q     <= batch_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      abort_req_q <= abort_req_d;
    end
  end

endmodule
